// File: rtl/cam_rgb565_capture.sv
// Camera byte-stream to RGB565 word capture with frame sequencing, size checking
// and FIFO overflow detection.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | disabled, waiting for i_en
// ST_SKIP    | discarding SKIP_FRAMES frames while the camera settles
// ST_WAIT_FS | armed, waiting for the next frame start
// ST_CAPTURE | assembling byte pairs into words and writing the FIFO
// ST_DROP    | word lost to a full FIFO, discarding the rest of the frame
module cam_rgb565_capture #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_data,
    input  logic        i_fifo_full,
    input  logic        i_clr,
    output logic        o_fifo_wr_en,
    output logic [15:0] o_fifo_wr_data,
    output logic        o_fifo_rec_work_en,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic        o_overflow
);

    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
    localparam logic [15:0] SKIP_N = 16'(SKIP_FRAMES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKIP,
        ST_WAIT_FS,
        ST_CAPTURE,
        ST_DROP
    } state_t;

    state_t      state_q;
    logic        vsync_q, vsync_prev_q;
    logic        href_q, href_prev_q;
    logic        byte_vld_q;
    logic [7:0]  data_q;
    logic [15:0] skip_cnt_q;
    logic        phase_q;
    logic [7:0]  byte0_q;
    logic [10:0] pix_cnt_q;
    logic [10:0] line_cnt_q;
    logic        wr_en_q;
    logic [15:0] wr_data_q;
    logic        work_en_q;
    logic        done_q;
    logic        err_q;
    logic        ovf_q;

    logic        frame_start, frame_end, href_fall;
    logic        in_capture, byte_in, word_done, odd_tail;
    logic [10:0] pix_next, line_next;
    logic        line_bad, frame_bad, err_set, ovf_set;

    // Edge detection runs on the registered copies of the camera inputs.
    assign frame_start = vsync_prev_q & ~vsync_q;
    assign frame_end   = ~vsync_prev_q & vsync_q;
    assign href_fall   = href_prev_q & ~href_q;

    assign in_capture = (state_q == ST_CAPTURE);
    assign byte_in    = in_capture & byte_vld_q & href_q;
    assign word_done  = byte_in & phase_q;
    assign odd_tail   = phase_q & ~word_done;

    // The completing word counts toward the line before the line-size check.
    assign pix_next  = (word_done && pix_cnt_q != 11'h7FF) ? pix_cnt_q + 11'd1 : pix_cnt_q;
    assign line_next = (href_fall && line_cnt_q != 11'h7FF) ? line_cnt_q + 11'd1 : line_cnt_q;

    assign line_bad  = href_fall & ((pix_next != H_LIM) | odd_tail);
    assign frame_bad = frame_end & (line_next != V_LIM);
    assign err_set   = in_capture & (line_bad | frame_bad);
    assign ovf_set   = word_done & i_fifo_full;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_q       <= 1'b0;
            href_prev_q  <= 1'b0;
            byte_vld_q   <= 1'b0;
            data_q       <= 8'h00;
            skip_cnt_q   <= 16'h0000;
            phase_q      <= 1'b0;
            byte0_q      <= 8'h00;
            pix_cnt_q    <= 11'h000;
            line_cnt_q   <= 11'h000;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 16'h0000;
            work_en_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            vsync_q      <= i_vsync;
            vsync_prev_q <= vsync_q;
            href_q       <= i_href;
            href_prev_q  <= href_q;
            byte_vld_q   <= i_byte_vld;
            data_q       <= i_data;

            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            work_en_q <= in_capture;
            // Set beats clear when both land in the same cycle.
            err_q     <= err_set | (err_q & ~i_clr);
            ovf_q     <= ovf_set | (ovf_q & ~i_clr);

            case (state_q)
                ST_IDLE: begin
                    phase_q    <= 1'b0;
                    pix_cnt_q  <= 11'h000;
                    line_cnt_q <= 11'h000;
                    if (i_en) begin
                        skip_cnt_q <= SKIP_N;
                        state_q    <= (SKIP_N == 16'h0000) ? ST_WAIT_FS : ST_SKIP;
                    end
                end

                ST_SKIP: begin
                    if (!i_en) begin
                        state_q <= ST_IDLE;
                    end else if (frame_start) begin
                        skip_cnt_q <= skip_cnt_q - 16'd1;
                        if (skip_cnt_q == 16'd1) begin
                            state_q <= ST_WAIT_FS;
                        end
                    end
                end

                ST_WAIT_FS: begin
                    phase_q    <= 1'b0;
                    pix_cnt_q  <= 11'h000;
                    line_cnt_q <= 11'h000;
                    if (!i_en) begin
                        state_q <= ST_IDLE;
                    end else if (frame_start) begin
                        state_q <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    if (frame_end) begin
                        done_q     <= 1'b1;
                        phase_q    <= 1'b0;
                        pix_cnt_q  <= 11'h000;
                        line_cnt_q <= 11'h000;
                        state_q    <= i_en ? ST_WAIT_FS : ST_IDLE;
                    end else begin
                        if (byte_in) begin
                            if (!phase_q) begin
                                byte0_q <= data_q;
                                phase_q <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                if (i_fifo_full) begin
                                    state_q <= ST_DROP;
                                end else begin
                                    wr_en_q   <= 1'b1;
                                    wr_data_q <= {byte0_q, data_q};
                                    pix_cnt_q <= pix_next;
                                end
                            end
                        end
                        if (href_fall) begin
                            phase_q    <= 1'b0;
                            pix_cnt_q  <= 11'h000;
                            line_cnt_q <= line_next;
                        end
                    end
                end

                ST_DROP: begin
                    phase_q <= 1'b0;
                    if (frame_end) begin
                        pix_cnt_q  <= 11'h000;
                        line_cnt_q <= 11'h000;
                        state_q    <= i_en ? ST_WAIT_FS : ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_fifo_wr_en       = wr_en_q;
    assign o_fifo_wr_data     = wr_data_q;
    assign o_fifo_rec_work_en = work_en_q;
    assign o_frame_done       = done_q;
    assign o_frame_err        = err_q;
    assign o_overflow         = ovf_q;

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Bench for cam_rgb565_capture: table-driven frame scenarios, randomized frames
// against a byte-pairing reference model, and hand-written enable/reset sequences.
module tb_cam_rgb565_capture;

    localparam int H = 4;
    localparam int V = 2;
    localparam int SK = 2;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0;
    logic        i_vsync = 1'b1;
    logic        i_href = 1'b0;
    logic        i_byte_vld = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        i_fifo_full = 1'b0;
    logic        i_clr = 1'b0;
    logic        o_fifo_wr_en;
    logic [15:0] o_fifo_wr_data;
    logic        o_fifo_rec_work_en;
    logic        o_frame_done;
    logic        o_frame_err;
    logic        o_overflow;

    cam_rgb565_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SK)) dut (
        .clk                (clk),
        .i_rst              (i_rst),
        .i_en               (i_en),
        .i_vsync            (i_vsync),
        .i_href             (i_href),
        .i_byte_vld         (i_byte_vld),
        .i_data             (i_data),
        .i_fifo_full        (i_fifo_full),
        .i_clr              (i_clr),
        .o_fifo_wr_en       (o_fifo_wr_en),
        .o_fifo_wr_data     (o_fifo_wr_data),
        .o_fifo_rec_work_en (o_fifo_rec_work_en),
        .o_frame_done       (o_frame_done),
        .o_frame_err        (o_frame_err),
        .o_overflow         (o_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed side
    logic [15:0] got_q[$];
    int          gcyc_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (o_fifo_wr_en) begin
            got_q.push_back(o_fifo_wr_data);
            gcyc_q.push_back(cyc);
        end
        if (o_frame_done) done_cnt++;
    end

    // Reference model side
    logic [15:0] exp_q[$];
    int          scyc_q[$];
    bit          exp_err;
    bit          exp_done;
    bit          exp_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_flags();
        @(negedge clk) i_clr = 1'b1;
        @(negedge clk) i_clr = 1'b0;
        @(negedge clk);
    endtask

    // Drive one frame; the model pairs bytes per line, drops the odd tail, and
    // stops collecting once a word meets a full FIFO.
    task automatic run_frame(input int lines, input int bpl_fixed, input int full_word,
                             input int drop_line, input bit cap, input bit rnd);
        int          bpl;
        int          wi;
        bit          dropped;
        logic [7:0]  val;
        logic [7:0]  prev;
        logic [7:0]  cnt;
        wi = 0; dropped = 0; cnt = 8'h01; prev = 8'h00;
        exp_q.delete(); scyc_q.delete(); got_q.delete(); gcyc_q.delete();
        done_cnt = 0; exp_err = 0;
        @(negedge clk) i_vsync = 1'b1;
        repeat (3) @(negedge clk);
        i_vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < lines; l++) begin
            bpl = rnd ? int'($urandom_range(7, 9)) : bpl_fixed;
            @(negedge clk) i_href = 1'b1;
            for (int k = 0; k < bpl; k++) begin
                @(negedge clk);
                val = rnd ? 8'($urandom) : cnt;
                cnt = cnt + 8'h01;
                i_byte_vld = 1'b1;
                i_data = val;
                if (k % 2 == 1) begin
                    if (cap && !dropped) begin
                        if (wi == full_word) begin
                            i_fifo_full = 1'b1;
                            dropped = 1;
                        end else begin
                            exp_q.push_back({prev, val});
                            scyc_q.push_back(cyc);
                        end
                    end
                    wi++;
                end else begin
                    prev = val;
                end
                @(negedge clk) i_byte_vld = 1'b0;
                if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            @(negedge clk) i_href = 1'b0;
            repeat (3) @(negedge clk);
            if (cap && !dropped && ((bpl % 2) != 0 || (bpl / 2) != H)) exp_err = 1;
            if (drop_line == l) i_en = 1'b0;
        end
        i_vsync = 1'b1;
        repeat (6) @(negedge clk);
        i_fifo_full = 1'b0;
        if (cap && !dropped && lines != V) exp_err = 1;
        exp_done = cap && !dropped;
        exp_ovf  = dropped;
    endtask

    task automatic check_frame(input string name, input int n_words, input bit done,
                               input bit err, input bit ovf);
        chk({name, " words"}, got_q.size(), n_words);
        chk({name, " done"}, done_cnt, done);
        chk({name, " err"}, o_frame_err, err);
        chk({name, " ovf"}, o_overflow, ovf);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({name, " data"}, got_q[i], exp_q[i]);
        if (got_q.size() > 0 && scyc_q.size() > 0)
            chk({name, " latency"}, gcyc_q[0] - scyc_q[0], 2);
    endtask

    typedef struct {
        int lines;
        int bpl;
        int full_word;
        int n_words;
        bit done;
        bit err;
        bit ovf;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{2, 8, -1,  8, 1'b1, 1'b0, 1'b0};
        vt[1] = '{2, 8,  2,  2, 1'b0, 1'b0, 1'b1};
        vt[2] = '{2, 8, -1,  8, 1'b1, 1'b0, 1'b0};
        vt[3] = '{2, 7, -1,  6, 1'b1, 1'b1, 1'b0};
        vt[4] = '{3, 8, -1, 12, 1'b1, 1'b1, 1'b0};
        vt[5] = '{1, 8, -1,  4, 1'b1, 1'b1, 1'b0};
        vt[6] = '{2, 10, -1, 10, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("rst wr_en", o_fifo_wr_en, 0);
        chk("rst wr_data", o_fifo_wr_data, 0);
        chk("rst work_en", o_fifo_rec_work_en, 0);
        chk("rst done", o_frame_done, 0);
        chk("rst err", o_frame_err, 0);
        chk("rst ovf", o_overflow, 0);

        // Settling frames then first captured frame of 0x01..0x10
        i_en = 1'b1;
        run_frame(2, 8, -1, -1, 0, 0);
        check_frame("skip1", 0, 0, 0, 0);
        run_frame(2, 8, -1, -1, 0, 0);
        check_frame("skip2", 0, 0, 0, 0);
        run_frame(2, 8, -1, -1, 1, 0);
        check_frame("first", 8, 1, 0, 0);
        chk("first word", (got_q.size() > 0) ? got_q[0] : 16'hXXXX, 16'h0102);

        for (int v = 0; v < 7; v++) begin
            clear_flags();
            chk($sformatf("vec%0d clr err", v), o_frame_err, 0);
            chk($sformatf("vec%0d clr ovf", v), o_overflow, 0);
            run_frame(vt[v].lines, vt[v].bpl, vt[v].full_word, -1, 1, 0);
            check_frame($sformatf("vec%0d", v), vt[v].n_words, vt[v].done, vt[v].err, vt[v].ovf);
        end

        for (int r = 0; r < 6; r++) begin
            clear_flags();
            run_frame($urandom_range(1, 3), 0, -1, -1, 1, 1);
            check_frame($sformatf("rnd%0d", r), exp_q.size(), exp_done, exp_err, exp_ovf);
        end

        // Enable dropped mid-frame: frame completes, then idle
        clear_flags();
        run_frame(2, 8, -1, 0, 1, 0);
        check_frame("endrop", 8, 1, 0, 0);
        chk("endrop work_en", o_fifo_rec_work_en, 0);
        run_frame(2, 8, -1, -1, 0, 0);
        check_frame("after endrop", 0, 0, 0, 0);

        // Reset after byte0 of a word in a captured frame
        i_en = 1'b1;
        run_frame(2, 8, -1, -1, 0, 0);
        run_frame(2, 8, -1, -1, 0, 0);
        got_q.delete(); done_cnt = 0;
        @(negedge clk) i_vsync = 1'b0;
        repeat (3) @(negedge clk);
        i_href = 1'b1;
        @(negedge clk) begin i_byte_vld = 1'b1; i_data = 8'hAA; end
        @(negedge clk) i_byte_vld = 1'b0;
        @(negedge clk);
        chk("pre-rst work_en", o_fifo_rec_work_en, 1);
        i_rst = 1'b1;
        @(negedge clk) i_rst = 1'b0;
        chk("mrst wr_en", o_fifo_wr_en, 0);
        chk("mrst work_en", o_fifo_rec_work_en, 0);
        chk("mrst err", o_frame_err, 0);
        chk("mrst ovf", o_overflow, 0);
        @(negedge clk) begin i_byte_vld = 1'b1; i_data = 8'hBB; end
        @(negedge clk) i_byte_vld = 1'b0;
        @(negedge clk) i_href = 1'b0;
        repeat (3) @(negedge clk);
        i_vsync = 1'b1;
        repeat (6) @(negedge clk);
        chk("mrst no write", got_q.size(), 0);
        chk("mrst no done", done_cnt, 0);
        run_frame(2, 8, -1, -1, 0, 0);
        check_frame("rskip1", 0, 0, 0, 0);
        run_frame(2, 8, -1, -1, 0, 0);
        check_frame("rskip2", 0, 0, 0, 0);
        run_frame(2, 8, -1, -1, 1, 0);
        check_frame("resume", 8, 1, 0, 0);
        chk("resume word", (got_q.size() > 0) ? got_q[0] : 16'hXXXX, 16'h0102);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_rgb565_capture.md
CAM_RGB565_CAPTURE -- requirements
Module: cam_rgb565_capture

Interface
REQ-001 Parameter H_ACTIVE, default 320: expected pixels (16-bit words) per line.
REQ-002 Parameter V_ACTIVE, default 240: expected lines per frame.
REQ-003 Parameter SKIP_FRAMES, default 10: frames discarded after enable, for camera settling.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_en  in  1  capture enable.
REQ-007 i_vsync  in  1  camera frame sync; high = vertical blanking.
REQ-008 i_href  in  1  camera line valid.
REQ-009 i_byte_vld  in  1  one-cycle strobe: i_data holds a valid byte.
REQ-010 i_data  in  8  camera pixel byte; RGB565 high byte first.
REQ-011 i_fifo_full  in  1  pixel FIFO full.
REQ-012 o_fifo_wr_en  out  1  FIFO write strobe.
REQ-013 o_fifo_wr_data  out  16  RGB565 word {byte0, byte1}.
REQ-014 o_fifo_rec_work_en  out  1  high while a frame is being written; downstream reader holds off.
REQ-015 o_frame_done  out  1  one-cycle pulse at end of a captured frame.
REQ-016 o_frame_err  out  1  sticky: line or frame size mismatch.
REQ-017 o_overflow  out  1  sticky: word lost to full FIFO.
REQ-018 i_clr  in  1  one-cycle clear of o_frame_err and o_overflow.

Function
REQ-019 i_vsync, i_href, i_byte_vld, i_data SHALL be registered once before use; all latencies below count from the port.
REQ-020 Frame start = falling edge of registered vsync; frame end = rising edge.
REQ-021 FSM states SHALL be IDLE, SKIP, WAIT_FS, CAPTURE, DROP.
REQ-022 IDLE -> SKIP when i_en=1; SKIP counts frame starts and goes to WAIT_FS after SKIP_FRAMES of them (SKIP_FRAMES=0 goes straight to WAIT_FS).
REQ-023 WAIT_FS -> CAPTURE on frame start when i_en=1; WAIT_FS -> IDLE when i_en=0.
REQ-024 CAPTURE -> WAIT_FS on frame end, or -> IDLE on frame end if i_en=0 (i_en drop mid-frame completes the frame).
REQ-025 o_fifo_rec_work_en SHALL equal (state==CAPTURE), registered.
REQ-026 In CAPTURE, byte phase toggles on each byte_vld with href=1; first byte stored, second byte completes the word.
REQ-027 On word completion with i_fifo_full=0: o_fifo_wr_en=1 and o_fifo_wr_data={byte0,byte1} exactly 2 cycles after the second byte's strobe at the port, for one cycle.
REQ-028 On word completion with i_fifo_full=1: no write, o_overflow<=1, state -> DROP; DROP -> WAIT_FS (or IDLE if i_en=0) on frame end, no o_frame_done.
REQ-029 Byte phase and pixel counter SHALL reset on each href falling edge; an odd trailing byte is discarded and sets o_frame_err.
REQ-030 At href falling edge, pixel count != H_ACTIVE sets o_frame_err; line counter increments (saturating at 11 bits).
REQ-031 At frame end in CAPTURE: o_frame_done pulses one cycle; line count != V_ACTIVE sets o_frame_err; counters clear.
REQ-032 Bytes with href=0, or outside CAPTURE, SHALL be ignored.
REQ-033 i_clr same cycle as a new error event: set wins.
REQ-034 Word completion and href fall same cycle: word written and counted before the line check.

Reset
REQ-035 i_rst=1 SHALL force state IDLE, all counters/phase 0, all outputs 0 on next edge, discarding any partial word; reset mid-frame resumes only via IDLE -> SKIP.

Verification
REQ-036 SKIP_FRAMES=2, H=4, V=2, frames of bytes 0x01..0x10: first two frames no writes; third frame writes 0x0102,0x0304,...,0x0F10 (8 words), one o_frame_done, o_frame_err=0.
REQ-037 i_fifo_full=1 at third word of captured frame -> 2 words written, o_overflow=1, no o_frame_done, next frame captured normally.
REQ-038 Line of 7 bytes with H=4 -> 3 words, o_frame_err=1; i_clr -> 0.
REQ-039 i_en dropped mid-CAPTURE -> frame completes with o_frame_done, then IDLE, o_fifo_rec_work_en=0, no further writes.
REQ-040 i_rst pulsed after byte0 of a word -> no write, all outputs 0; after re-enable first word uses fresh byte pair.
